// File: rtl/vec_proc_pkg.sv
// rtl/vec_proc_pkg.sv - shared types and saturation helper for the vector processor
package vec_proc_pkg;

   typedef enum logic [1:0] {
      MODE_MUL   = 2'b00,
      MODE_SCALE = 2'b01,
      MODE_ADD   = 2'b10,
      MODE_DOT   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPUTE,
      ST_REDUCE,
      ST_FINISH
   } state_t;

   // Width of the intermediate domain every value is widened into before clamping.
   localparam int SAT_W = 64;

   // Clamp a wide signed value into the signed range of a 'width'-bit number.
   function automatic logic signed [SAT_W-1:0] sat_trunc(
      input logic signed [SAT_W-1:0] value,
      input int                      width
   );
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v)
         sat_trunc = max_v;
      else if (value < min_v)
         sat_trunc = min_v;
      else
         sat_trunc = value;
   endfunction

endpackage

// File: rtl/vec_proc_lane.sv
// rtl/vec_proc_lane.sv - one combinational processing lane (mul/scale/add with saturation, raw dot product)
module vec_proc_lane
   import vec_proc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8
) (
   input  logic signed [DATA_WIDTH-1:0]   a,
   input  logic signed [DATA_WIDTH-1:0]   b,
   input  logic signed [DATA_WIDTH-1:0]   scale,
   input  mode_t                          mode,
   input  logic                           mask,
   output logic signed [DATA_WIDTH-1:0]   result,
   output logic                           sat,
   output logic signed [2*DATA_WIDTH-1:0] product
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] operand;
   logic signed [PROD_W-1:0]     full;
   logic signed [SAT_W-1:0]      wide;
   logic signed [SAT_W-1:0]      clamped;

   always_comb begin
      operand = (mode == MODE_SCALE) ? scale : b;
      full    = PROD_W'(a) * PROD_W'(operand);
      if (mode == MODE_ADD)
         wide = SAT_W'(a) + SAT_W'(b);
      else
         wide = SAT_W'(full >>> FRAC_BITS);
      clamped = sat_trunc(wide, DATA_WIDTH);
      // Masked lanes sit past the end of a ragged vector and must stay inert.
      result  = mask ? '0 : DATA_WIDTH'(clamped);
      sat     = !mask && (mode != MODE_DOT) && (clamped != wide);
      product = (mask || mode != MODE_DOT) ? '0 : full;
   end

endmodule

// File: rtl/vec_processor_pipelined.sv
// rtl/vec_processor_pipelined.sv - multi-lane vector engine: element-wise ops and lane-parallel dot product
module vec_processor_pipelined
   import vec_proc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int VEC_LEN    = 16,
   parameter int NUM_PES    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   mode,
   input  logic signed [DATA_WIDTH-1:0] scale,
   input  logic signed [DATA_WIDTH-1:0] data_in_a [VEC_LEN],
   input  logic signed [DATA_WIDTH-1:0] data_in_b [VEC_LEN],
   output logic signed [DATA_WIDTH-1:0] data_out  [VEC_LEN],
   output logic                         busy,
   output logic                         done,
   output logic                         sat_flag
);

   localparam int PASSES = (VEC_LEN + NUM_PES - 1) / NUM_PES;
   localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam int PW     = 2 * DATA_WIDTH + $clog2(VEC_LEN) + 1;

   state_t                       state;
   mode_t                        mode_q;
   logic signed [DATA_WIDTH-1:0] scale_q;
   logic signed [DATA_WIDTH-1:0] a_q    [VEC_LEN];
   logic signed [DATA_WIDTH-1:0] b_q    [VEC_LEN];
   logic signed [DATA_WIDTH-1:0] buffer [VEC_LEN];
   logic signed [PW-1:0]         partial [NUM_PES];
   logic [CNT_W-1:0]             pass_cnt;
   logic                         sat_acc;

   logic signed [DATA_WIDTH-1:0]   lane_a    [NUM_PES];
   logic signed [DATA_WIDTH-1:0]   lane_b    [NUM_PES];
   logic                           lane_mask [NUM_PES];
   logic signed [DATA_WIDTH-1:0]   lane_res  [NUM_PES];
   logic                           lane_sat  [NUM_PES];
   logic signed [2*DATA_WIDTH-1:0] lane_prod [NUM_PES];
   logic                           any_sat;

   logic signed [PW-1:0]    dot_sum;
   logic signed [SAT_W-1:0] dot_wide;
   logic signed [SAT_W-1:0] dot_clamped;
   logic                    dot_sat;

   // Route element pass_cnt*NUM_PES + j to lane j.
   always_comb begin
      for (int j = 0; j < NUM_PES; j++) begin
         lane_a[j]    = '0;
         lane_b[j]    = '0;
         lane_mask[j] = (int'(pass_cnt) * NUM_PES + j) >= VEC_LEN;
      end
      for (int e = 0; e < VEC_LEN; e++) begin
         if (e / NUM_PES == int'(pass_cnt)) begin
            lane_a[e % NUM_PES] = a_q[e];
            lane_b[e % NUM_PES] = b_q[e];
         end
      end
   end

   for (genvar j = 0; j < NUM_PES; j++) begin : g_lane
      vec_proc_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS)
      ) u_lane (
         .a       (lane_a[j]),
         .b       (lane_b[j]),
         .scale   (scale_q),
         .mode    (mode_q),
         .mask    (lane_mask[j]),
         .result  (lane_res[j]),
         .sat     (lane_sat[j]),
         .product (lane_prod[j])
      );
   end

   always_comb begin
      any_sat = 1'b0;
      dot_sum = '0;
      for (int j = 0; j < NUM_PES; j++) begin
         any_sat = any_sat | lane_sat[j];
         dot_sum = dot_sum + partial[j];
      end
      dot_wide    = SAT_W'(dot_sum >>> FRAC_BITS);
      dot_clamped = sat_trunc(dot_wide, DATA_WIDTH);
      dot_sat     = dot_clamped != dot_wide;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_MUL;
         scale_q  <= '0;
         pass_cnt <= '0;
         sat_acc  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sat_flag <= 1'b0;
         for (int e = 0; e < VEC_LEN; e++) begin
            a_q[e]      <= '0;
            b_q[e]      <= '0;
            buffer[e]   <= '0;
            data_out[e] <= '0;
         end
         for (int j = 0; j < NUM_PES; j++)
            partial[j] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_COMPUTE;
                  mode_q   <= mode_t'(mode);
                  scale_q  <= scale;
                  a_q      <= data_in_a;
                  b_q      <= data_in_b;
                  pass_cnt <= '0;
                  sat_acc  <= 1'b0;
                  busy     <= 1'b1;
                  for (int j = 0; j < NUM_PES; j++)
                     partial[j] <= '0;
               end
            end
            ST_COMPUTE: begin
               for (int j = 0; j < NUM_PES; j++)
                  if (mode_q == MODE_DOT)
                     partial[j] <= partial[j] + PW'(lane_prod[j]);
               for (int e = 0; e < VEC_LEN; e++)
                  if (mode_q != MODE_DOT && e / NUM_PES == int'(pass_cnt))
                     buffer[e] <= lane_res[e % NUM_PES];
               if (any_sat)
                  sat_acc <= 1'b1;
               if (int'(pass_cnt) == PASSES - 1) begin
                  pass_cnt <= '0;
                  state    <= (mode_q == MODE_DOT) ? ST_REDUCE : ST_FINISH;
               end else begin
                  pass_cnt <= pass_cnt + CNT_W'(1);
               end
            end
            ST_REDUCE: begin
               for (int e = 0; e < VEC_LEN; e++) begin
                  if (e == 0)
                     buffer[e] <= DATA_WIDTH'(dot_clamped);
                  else
                     buffer[e] <= '0;
               end
               if (dot_sat)
                  sat_acc <= 1'b1;
               state <= ST_FINISH;
            end
            ST_FINISH: begin
               data_out <= buffer;
               sat_flag <= sat_acc;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_processor_pipelined.sv
// tb/tb_vec_processor_pipelined.sv - directed self-checking bench for vec_processor_pipelined
module tb_vec_processor_pipelined;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start16 = 1'b0;
   logic [1:0]        mode16 = 2'b00;
   logic signed [15:0] scale16 = '0;
   logic signed [15:0] a16 [16];
   logic signed [15:0] b16 [16];
   logic signed [15:0] out16 [16];
   logic              busy16, done16, sat16;

   logic              start10 = 1'b0;
   logic [1:0]        mode10 = 2'b00;
   logic signed [15:0] scale10 = '0;
   logic signed [15:0] a10 [10];
   logic signed [15:0] b10 [10];
   logic signed [15:0] out10 [10];
   logic              busy10, done10, sat10;

   int checks = 0;
   int errors = 0;

   vec_processor_pipelined #(.DATA_WIDTH(16), .FRAC_BITS(8), .VEC_LEN(16), .NUM_PES(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .mode(mode16), .scale(scale16),
      .data_in_a(a16), .data_in_b(b16), .data_out(out16),
      .busy(busy16), .done(done16), .sat_flag(sat16)
   );

   vec_processor_pipelined #(.DATA_WIDTH(16), .FRAC_BITS(8), .VEC_LEN(10), .NUM_PES(4)) dut10 (
      .clk(clk), .rst(rst), .start(start10), .mode(mode10), .scale(scale10),
      .data_in_a(a10), .data_in_b(b10), .data_out(out10),
      .busy(busy10), .done(done10), .sat_flag(sat10)
   );

   // Load a MUL op on dut16: a[i] = m*0x100, b[i] = i<<4, so out[i] = m*i*16.
   task automatic load_mul16(input int m);
      mode16 = 2'b00;
      for (int i = 0; i < 16; i++) begin
         a16[i] = 16'(m * 256);
         b16[i] = 16'(i << 4);
      end
   endtask

   // Pulse start on dut16 and return cycles from accept edge until done is seen (-1 on timeout).
   task automatic run16(output int lat);
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done16) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run10(output int lat);
      start10 = 1'b1;
      @(posedge clk); #1;
      start10 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done10) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if (busy16 !== 1'b0 || done16 !== 1'b0 || sat16 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b sat=%b required 0 0 0", busy16, done16, sat16);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out16[i] !== 16'sh0000) begin
            errors++;
            $display("FAIL reset_out[%0d]: got %h required 0000", i, out16[i]);
         end
      end
   endtask

   task automatic test_mul();
      int lat;
      mode16 = 2'b00;
      for (int i = 0; i < 16; i++) begin
         a16[i] = 16'sh0100;
         b16[i] = 16'(i << 8);
      end
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      checks++;
      if (busy16 !== 1'b1) begin
         errors++;
         $display("FAIL mul_busy: got %b required 1", busy16);
      end
      for (int i = 0; i < 16; i++) a16[i] = 16'sh7FFF;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (done16) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL mul_latency: got %0d required 5", lat);
      end
      checks++;
      if (busy16 !== 1'b0) begin
         errors++;
         $display("FAIL mul_busy_fall: got %b required 0", busy16);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out16[i] !== 16'(i << 8)) begin
            errors++;
            $display("FAIL mul_out[%0d]: got %h required %h", i, out16[i], 16'(i << 8));
         end
      end
      checks++;
      if (sat16 !== 1'b0) begin
         errors++;
         $display("FAIL mul_sat: got %b required 0", sat16);
      end
      @(posedge clk); #1;
      checks++;
      if (done16 !== 1'b0) begin
         errors++;
         $display("FAIL mul_done_width: got %b required 0", done16);
      end
   endtask

   task automatic test_dot();
      int lat;
      mode16 = 2'b11;
      for (int i = 0; i < 16; i++) begin
         a16[i] = 16'sh0100;
         b16[i] = 16'sh0100;
      end
      run16(lat);
      checks++;
      if (lat !== 6) begin
         errors++;
         $display("FAIL dot_latency: got %0d required 6", lat);
      end
      checks++;
      if (out16[0] !== 16'sh1000) begin
         errors++;
         $display("FAIL dot_out0: got %h required 1000", out16[0]);
      end
      for (int i = 1; i < 16; i++) begin
         checks++;
         if (out16[i] !== 16'sh0000) begin
            errors++;
            $display("FAIL dot_out[%0d]: got %h required 0000", i, out16[i]);
         end
      end
      checks++;
      if (sat16 !== 1'b0) begin
         errors++;
         $display("FAIL dot_sat_clean: got %b required 0", sat16);
      end
      for (int i = 0; i < 16; i++) begin
         a16[i] = 16'sh7FFF;
         b16[i] = 16'sh7FFF;
      end
      run16(lat);
      checks++;
      if (out16[0] !== 16'sh7FFF || sat16 !== 1'b1) begin
         errors++;
         $display("FAIL dot_saturate: got %h sat=%b required 7fff sat=1", out16[0], sat16);
      end
   endtask

   task automatic test_add_saturation();
      int lat;
      mode16 = 2'b10;
      for (int i = 0; i < 16; i++) begin
         a16[i] = 16'(i);
         b16[i] = 16'sh0001;
      end
      a16[0] = 16'sh7000; b16[0] = 16'sh7000;
      a16[1] = -16'sh7000; b16[1] = -16'sh7000;
      run16(lat);
      checks++;
      if (out16[0] !== 16'sh7FFF) begin
         errors++;
         $display("FAIL add_pos_sat: got %h required 7fff", out16[0]);
      end
      checks++;
      if (out16[1] !== 16'sh8000) begin
         errors++;
         $display("FAIL add_neg_sat: got %h required 8000", out16[1]);
      end
      for (int i = 2; i < 16; i++) begin
         checks++;
         if (out16[i] !== 16'(i + 1)) begin
            errors++;
            $display("FAIL add_out[%0d]: got %h required %h", i, out16[i], 16'(i + 1));
         end
      end
      checks++;
      if (sat16 !== 1'b1) begin
         errors++;
         $display("FAIL add_sat_flag: got %b required 1", sat16);
      end
      // Clean MUL afterwards; element 15 checks the arithmetic shift on a negative product.
      mode16 = 2'b00;
      for (int i = 0; i < 16; i++) begin
         a16[i] = 16'sh0200;
         b16[i] = 16'(i << 8);
      end
      a16[15] = -16'sh0001; b16[15] = 16'sh0001;
      run16(lat);
      checks++;
      if (sat16 !== 1'b0) begin
         errors++;
         $display("FAIL mul_after_sat_flag: got %b required 0", sat16);
      end
      checks++;
      if (out16[7] !== 16'sh0E00) begin
         errors++;
         $display("FAIL mul_after_sat_out7: got %h required 0e00", out16[7]);
      end
      checks++;
      if (out16[15] !== 16'shFFFF) begin
         errors++;
         $display("FAIL mul_neg_floor: got %h required ffff", out16[15]);
      end
   endtask

   task automatic test_ragged();
      int lat;
      mode10 = 2'b01;
      scale10 = 16'sh0200;
      for (int i = 0; i < 10; i++) begin
         a10[i] = 16'(i);
         b10[i] = 16'sh7FFF;
      end
      run10(lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL ragged_scale_latency: got %0d required 4", lat);
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out10[i] !== 16'(2 * i)) begin
            errors++;
            $display("FAIL ragged_scale_out[%0d]: got %h required %h", i, out10[i], 16'(2 * i));
         end
      end
      mode10 = 2'b11;
      for (int i = 0; i < 10; i++) begin
         a10[i] = 16'sh0100;
         b10[i] = 16'sh0100;
      end
      run10(lat);
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL ragged_dot_latency: got %0d required 5", lat);
      end
      checks++;
      if (out10[0] !== 16'sh0A00 || out10[9] !== 16'sh0000) begin
         errors++;
         $display("FAIL ragged_dot_out: got %h/%h required 0a00/0000", out10[0], out10[9]);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      int seen;
      load_mul16(1);
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy16 !== 1'b0 || done16 !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ctrl: busy=%b done=%b required 0 0", busy16, done16);
      end
      checks++;
      if (out16[7] !== 16'sh0000 || out16[15] !== 16'sh0000) begin
         errors++;
         $display("FAIL rstmid_out: got %h/%h required 0000/0000", out16[7], out16[15]);
      end
      seen = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (done16) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL rstmid_no_done: got %0d pulses required 0", seen);
      end
      load_mul16(2);
      run16(lat);
      checks++;
      if (lat !== 5 || out16[15] !== 16'sh01E0) begin
         errors++;
         $display("FAIL rstmid_recover: lat=%0d out15=%h required 5 01e0", lat, out16[15]);
      end
   endtask

   task automatic test_start_while_busy();
      int seen;
      load_mul16(1);
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      @(posedge clk); #1;
      mode16 = 2'b10;
      for (int i = 0; i < 16; i++) a16[i] = 16'sh0300;
      start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      seen = 0;
      for (int n = 0; n < 15; n++) begin
         @(posedge clk); #1;
         if (done16) seen++;
      end
      checks++;
      if (seen !== 1) begin
         errors++;
         $display("FAIL busy_start_pulses: got %0d required 1", seen);
      end
      checks++;
      if (out16[10] !== 16'sh00A0) begin
         errors++;
         $display("FAIL busy_start_result: got %h required 00a0", out16[10]);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      int last;
      bit got;
      load_mul16(1);
      start16 = 1'b1;
      @(posedge clk); #1;
      c = 0;
      last = 0;
      load_mul16(2);
      for (int k = 0; k < 3; k++) begin
         got = 1'b0;
         for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            c++;
            if (done16) got = 1'b1;
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL b2b_timeout op%0d: no done within 20 cycles", k);
         end else begin
            for (int i = 0; i < 16; i++) begin
               checks++;
               if (out16[i] !== 16'((k + 1) * i * 16)) begin
                  errors++;
                  $display("FAIL b2b_out op%0d[%0d]: got %h required %h", k, i, out16[i], 16'((k + 1) * i * 16));
               end
            end
            if (k > 0) begin
               checks++;
               if (c - last !== 6) begin
                  errors++;
                  $display("FAIL b2b_spacing op%0d: got %0d required 6", k, c - last);
               end
            end
         end
         last = c;
         if (k < 2) begin
            @(posedge clk); #1;
            c++;
            if (k == 1) start16 = 1'b0;
            else load_mul16(3);
         end
      end
      start16 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy16 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b required 0", busy16);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         a16[i] = '0;
         b16[i] = '0;
      end
      for (int i = 0; i < 10; i++) begin
         a10[i] = '0;
         b10[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_mul();
      test_dot();
      test_add_saturation();
      test_ragged();
      test_reset_mid_op();
      test_start_while_busy();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
